// File: rtl/branch_ctrl.sv
// Branch resolution controller: captures a branch, drives the external comparator
// for one cycle, then holds the resolved next-PC until fetch accepts it.
module branch_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_bf,
  input  logic [31:0] req_pc,
  input  logic [15:0] req_imm,
  output logic [31:0] bce_a,
  output logic [31:0] bce_b,
  output logic [3:0]  bce_bf,
  input  logic        bce_bcres,
  output logic        redir_valid,
  input  logic        redir_ready,
  output logic [31:0] redir_pc,
  output logic        redir_taken,
  output logic        flush,
  output logic        illegal,
  output logic [15:0] taken_cnt
);

  typedef enum logic [1:0] {IDLE = 2'd0, EVAL = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  bf;
    logic [31:0] pc;
    logic [15:0] imm;
  } br_req_t;

  state_t      state;
  br_req_t     cap;
  logic        req_ready_q, redir_valid_q, taken_q, flush_q, illegal_q;
  logic [31:0] redir_pc_q;
  logic [15:0] cnt_q;

  logic        bf_ok, taken_n;
  logic [31:0] seq_pc, tgt_pc;

  always_comb begin
    bf_ok = 1'b0;
    case (cap.bf)
      4'b0010, 4'b0011, 4'b1000, 4'b1001, 4'b1010, 4'b1011: bf_ok = 1'b1;
      default: bf_ok = 1'b0;
    endcase
  end

  // Comparator output is only trusted for codes it actually implements.
  assign taken_n = bf_ok & bce_bcres;
  assign seq_pc  = cap.pc + 32'd4;
  assign tgt_pc  = seq_pc + {{14{cap.imm[15]}}, cap.imm, 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cap           <= '0;
      req_ready_q   <= 1'b1;
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      taken_q       <= 1'b0;
      flush_q       <= 1'b0;
      illegal_q     <= 1'b0;
      cnt_q         <= '0;
    end else begin
      // flush/illegal are single-cycle pulses on RESP entry only
      flush_q   <= 1'b0;
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            cap.a       <= req_a;
            cap.b       <= req_b;
            cap.bf      <= req_bf;
            cap.pc      <= req_pc;
            cap.imm     <= req_imm;
            req_ready_q <= 1'b0;
            state       <= EVAL;
          end
        end
        EVAL: begin
          taken_q       <= taken_n;
          redir_pc_q    <= taken_n ? tgt_pc : seq_pc;
          flush_q       <= taken_n;
          illegal_q     <= ~bf_ok;
          redir_valid_q <= 1'b1;
          if (taken_n && cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
          state         <= RESP;
        end
        RESP: begin
          if (redir_ready) begin
            redir_valid_q <= 1'b0;
            req_ready_q   <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          redir_valid_q <= 1'b0;
          req_ready_q   <= 1'b1;
          state         <= IDLE;
        end
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign bce_a       = cap.a;
  assign bce_b       = cap.b;
  assign bce_bf      = cap.bf;
  assign redir_valid = redir_valid_q;
  assign redir_pc    = redir_pc_q;
  assign redir_taken = taken_q;
  assign flush       = flush_q;
  assign illegal     = illegal_q;
  assign taken_cnt   = cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Bench for branch_ctrl with a behavioural branch comparator on the bce_* port
// and a spec-level reference model for redirect PC, taken, pulses and counter.
module tb_branch_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, redir_ready = 1'b0;
  logic [31:0] req_a = '0, req_b = '0, req_pc = '0;
  logic [3:0]  req_bf = '0;
  logic [15:0] req_imm = '0;
  logic        req_ready, bce_bcres, redir_valid, redir_taken, flush, illegal;
  logic [31:0] bce_a, bce_b, redir_pc;
  logic [3:0]  bce_bf;
  logic [15:0] taken_cnt;

  int checks = 0, errors = 0;
  logic [15:0] m_cnt = '0;

  branch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_bf(req_bf), .req_pc(req_pc), .req_imm(req_imm),
    .bce_a(bce_a), .bce_b(bce_b), .bce_bf(bce_bf), .bce_bcres(bce_bcres),
    .redir_valid(redir_valid), .redir_ready(redir_ready), .redir_pc(redir_pc),
    .redir_taken(redir_taken), .flush(flush), .illegal(illegal), .taken_cnt(taken_cnt)
  );

  always #5 clk = ~clk;

  // Branch comparator: sign/zero based; undefined codes answer 1 so gating is exercised.
  always_comb begin
    case (bce_bf)
      4'b0010: bce_bcres = bce_a[31];
      4'b0011: bce_bcres = ~bce_a[31];
      4'b1000: bce_bcres = (bce_a == bce_b);
      4'b1001: bce_bcres = (bce_a != bce_b);
      4'b1010: bce_bcres = bce_a[31] | (bce_a == 32'd0);
      4'b1011: bce_bcres = ~bce_a[31] & (bce_a != 32'd0);
      default: bce_bcres = 1'b1;
    endcase
  end

  function automatic logic ref_legal(input logic [3:0] f);
    return f inside {4'd2, 4'd3, 4'd8, 4'd9, 4'd10, 4'd11};
  endfunction

  function automatic logic ref_taken(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa;
    sa = int'(a);
    case (f)
      4'd2:    return sa < 0;
      4'd3:    return sa >= 0;
      4'd8:    return a == b;
      4'd9:    return a != b;
      4'd10:   return sa <= 0;
      4'd11:   return sa > 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk1(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0b expected %0b", tag, got, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk1({tag, "_ready"}, req_ready, 1'b1);
    chk1({tag, "_rvalid"}, redir_valid, 1'b0);
    chkv({tag, "_rpc"}, redir_pc, 32'd0);
    chk1({tag, "_taken"}, redir_taken, 1'b0);
    chk1({tag, "_flush"}, flush, 1'b0);
    chk1({tag, "_illegal"}, illegal, 1'b0);
    chkv({tag, "_cnt"}, 32'(taken_cnt), 32'd0);
    chkv({tag, "_bce_a"}, bce_a, 32'd0);
    chkv({tag, "_bce_b"}, bce_b, 32'd0);
    chkv({tag, "_bce_bf"}, 32'(bce_bf), 32'd0);
  endtask

  // One branch transaction; abort_at 1 = reset in EVAL, 2 = reset in first RESP cycle.
  task automatic run_branch(input logic [31:0] a, input logic [31:0] b, input logic [31:0] pc,
                            input logic [3:0] f, input logic [15:0] imm,
                            input int stall, input int abort_at);
    logic t, ok;
    int off;
    logic [31:0] epc;
    ok  = ref_legal(f);
    t   = ok && ref_taken(f, a, b);
    off = int'($signed(imm)) * 4;
    epc = pc + 32'd4 + (t ? 32'(off) : 32'd0);

    @(negedge clk);
    chk1("idle_ready", req_ready, 1'b1);
    req_valid = 1'b1; req_a = a; req_b = b; req_pc = pc; req_bf = f; req_imm = imm;
    redir_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    // EVAL: junk request must be ignored and the comparator inputs held
    req_a = $urandom; req_b = $urandom; req_bf = 4'($urandom); req_pc = $urandom;
    chk1("eval_ready", req_ready, 1'b0);
    chk1("eval_rvalid", redir_valid, 1'b0);
    chkv("eval_bce_a", bce_a, a);
    chkv("eval_bce_b", bce_b, b);
    chkv("eval_bce_bf", 32'(bce_bf), 32'(f));
    if (abort_at == 1) begin
      rst_n = 1'b0; #1;
      m_cnt = '0;
      chk_reset_outputs("rst_eval");
      @(negedge clk);
      rst_n = 1'b1; req_valid = 1'b0; redir_ready = 1'b0;
      return;
    end
    redir_ready = (stall == 0);
    @(negedge clk);
    if (t && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    chk1("resp_rvalid", redir_valid, 1'b1);
    chkv("resp_pc", redir_pc, epc);
    chk1("resp_taken", redir_taken, t);
    chk1("resp_flush", flush, t);
    chk1("resp_illegal", illegal, ~ok);
    chkv("resp_cnt", 32'(taken_cnt), 32'(m_cnt));
    chk1("resp_ready", req_ready, 1'b0);
    chkv("resp_bce_a", bce_a, a);
    if (abort_at == 2) begin
      rst_n = 1'b0; #1;
      m_cnt = '0;
      chk_reset_outputs("rst_resp");
      @(negedge clk);
      rst_n = 1'b1; req_valid = 1'b0; redir_ready = 1'b0;
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk1("stall_rvalid", redir_valid, 1'b1);
      chkv("stall_pc", redir_pc, epc);
      chk1("stall_taken", redir_taken, t);
      chk1("stall_flush", flush, 1'b0);
      chk1("stall_illegal", illegal, 1'b0);
      chk1("stall_ready", req_ready, 1'b0);
      chkv("stall_bce_a", bce_a, a);
      redir_ready = (i == stall - 1);
    end
    @(negedge clk);
    // req_valid was high on the completing edge: must land in IDLE, not EVAL
    chk1("done_rvalid", redir_valid, 1'b0);
    chk1("done_ready", req_ready, 1'b1);
    chk1("done_flush", flush, 1'b0);
    chkv("done_cnt", 32'(taken_cnt), 32'(m_cnt));
    req_valid = 1'b0; redir_ready = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // redir_ready in IDLE has no effect
    redir_ready = 1'b1;
    @(negedge clk);
    chk1("idle_rr_ready", req_ready, 1'b1);
    chk1("idle_rr_rvalid", redir_valid, 1'b0);
    redir_ready = 1'b0;

    run_branch(32'd5, 32'd5, 32'h0040_0000, 4'b1000, 16'h0004, 0, 0);
    chkv("s1_cnt_lit", 32'(taken_cnt), 32'd1);
    run_branch(32'd5, 32'd5, 32'h0040_0000, 4'b1001, 16'hFFFF, 0, 0);
    run_branch(32'd5, 32'd3, 32'h0040_0000, 4'b1001, 16'hFFFF, 0, 0);
    run_branch(-32'sd5, 32'd0, 32'h0000_0100, 4'b0010, 16'hFFFE, 0, 0);
    run_branch(32'd0, 32'd9, 32'h0000_0100, 4'b1011, 16'hFFFE, 0, 0);
    run_branch(32'd7, 32'd7, 32'h0000_0200, 4'b0101, 16'h0010, 0, 0);
    run_branch(32'd1, 32'd1, 32'h0000_0300, 4'b1000, 16'h0020, 5, 0);
    run_branch(32'd0, 32'd0, 32'h0000_0400, 4'b1010, 16'h0002, 2, 0);
    run_branch(32'h8000_0000, 32'd0, 32'h0000_0500, 4'b0011, 16'h0002, 1, 0);
    run_branch(32'd7, 32'd7, 32'hFFFF_FFFC, 4'b1000, 16'h0001, 0, 0);
    run_branch(32'd7, 32'd7, 32'h0000_0010, 4'b1000, 16'h8000, 0, 0);

    for (int n = 0; n < 40; n++) begin
      logic [31:0] ra, rb;
      ra = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      rb = ($urandom_range(0, 1) == 0) ? ra : $urandom;
      run_branch(ra, rb, $urandom, 4'($urandom_range(0, 15)), 16'($urandom),
                 $urandom_range(0, 3), 0);
    end

    run_branch(32'd1, 32'd1, 32'h0000_0040, 4'b1000, 16'h0003, 0, 2);
    run_branch(32'd1, 32'd1, 32'h0000_0040, 4'b1000, 16'h0003, 0, 1);
    run_branch(32'd2, 32'd3, 32'h0000_0080, 4'b1001, 16'h0004, 0, 0);

    // saturation: preload near the top, then two taken branches
    @(negedge clk);
    force dut.cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.cnt_q;
    m_cnt = 16'hFFFE;
    chkv("preload_cnt", 32'(taken_cnt), 32'h0000_FFFE);
    run_branch(32'd4, 32'd4, 32'h0000_1000, 4'b1000, 16'h0001, 0, 0);
    chkv("sat_cnt1", 32'(taken_cnt), 32'h0000_FFFF);
    run_branch(32'd4, 32'd4, 32'h0000_1000, 4'b1000, 16'h0001, 1, 0);
    chkv("sat_cnt2", 32'(taken_cnt), 32'h0000_FFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
